recorder_control: RTL and testbench



---
 rtl/recorder_control_if.sv | 40 ++++
 rtl/recorder_control.sv | 206 ++++++++++++++++++++
 tb/tb_recorder_control.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/recorder_control_if.sv
// ----------------------------------------------------------------------------
// recorder_control_if
// Groups the key pulses, mode switches, audio-core stop pulse and the
// registered outputs of recorder_control into one bundle.
//   i_key_play/stop/record/up/down : 1-cycle key pulses from the debouncers
//   i_sw_mode[1:0]                 : 00 normal, 01 slow, 10 fast, 11 normal
//   i_sw_interpol                  : slow-mode interpolation enable
//   i_stop_signal                  : end-of-data pulse from the audio core
//   o_event[15:0]                  : event word sampled by the audio core
//   o_state[2:0]                   : current control state
//   o_speed[3:0]                   : speed setting 1..8 for the display
//   o_seconds[7:0]                 : elapsed seconds for the display
// The master modport drives the inputs; the slave modport is the block.
// ----------------------------------------------------------------------------
interface recorder_control_if;
   logic        i_key_play;
   logic        i_key_stop;
   logic        i_key_record;
   logic        i_key_up;
   logic        i_key_down;
   logic [1:0]  i_sw_mode;
   logic        i_sw_interpol;
   logic        i_stop_signal;
   logic [15:0] o_event;
   logic [2:0]  o_state;
   logic [3:0]  o_speed;
   logic [7:0]  o_seconds;

   modport master (
      output i_key_play, i_key_stop, i_key_record, i_key_up, i_key_down,
      output i_sw_mode, i_sw_interpol, i_stop_signal,
      input  o_event, o_state, o_speed, o_seconds
   );

   modport slave (
      input  i_key_play, i_key_stop, i_key_record, i_key_up, i_key_down,
      input  i_sw_mode, i_sw_interpol, i_stop_signal,
      output o_event, o_state, o_speed, o_seconds
   );
endinterface

// File: rtl/recorder_control.sv
// ----------------------------------------------------------------------------
// recorder_control
// Command stage of the audio recorder: turns key pulses and mode switches
// into the registered 16-bit event word for the audio core, and keeps an
// elapsed-seconds counter for the display.
// Ports:
//   i_clk  : system clock
//   i_rst  : synchronous, active-high reset
//   bus    : recorder_control_if.slave (keys, switches, stop pulse, outputs)
// Parameters:
//   TICKS_PER_SEC : clock cycles per elapsed second
//   MAX_SECONDS   : recording capacity; the seconds counter saturates here
// Build option:
//   REC_AUTOSTOP_EN : when defined, RECORD returns to IDLE on the edge after
//                     the seconds counter reaches MAX_SECONDS.
// ----------------------------------------------------------------------------
module recorder_control #(
   parameter int TICKS_PER_SEC = 12000000,
   parameter int MAX_SECONDS   = 32
) (
   input  logic               i_clk,
   input  logic               i_rst,
   recorder_control_if.slave  bus
);

   localparam int TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SEC - 1);
   localparam logic [7:0] SEC_MAX = 8'(MAX_SECONDS);

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      PLAY         = 3'd1,
      PLAY_PAUSE   = 3'd2,
      RECORD       = 3'd3,
      RECORD_PAUSE = 3'd4
   } state_e;

   state_e        state_q, state_d;
   logic [3:0]    speed_q, speed_d;
   logic [TICK_W-1:0] tick_q, tick_d;
   logic [7:0]    seconds_q, seconds_d;
   logic [15:0]   event_q, event_d;
   logic          clearTimer;
   logic          stopSigEff;
   logic          keyEvent;
   logic [1:0]    modeField;
   logic [3:0]    speedField;
   logic          interpBit;

   // States in which the mode/speed/interpol fields may follow the inputs
   function automatic logic isCfgState(input state_e s);
      return (s == IDLE) || (s == PLAY_PAUSE) || (s == RECORD_PAUSE);
   endfunction

   function automatic logic [3:0] codeOf(input state_e s);
      case (s)
         PLAY:         return 4'd1;
         PLAY_PAUSE:   return 4'd2;
         RECORD:       return 4'd4;
         RECORD_PAUSE: return 4'd2;
         default:      return 4'd3;
      endcase
   endfunction

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. Keys are resolved in priority order
   // stop_signal > stop > record > play; the highest pulse present decides,
   // even when its action in the current state is "no change".
   always_comb begin
      state_d    = state_q;
      clearTimer = 1'b0;
      stopSigEff = bus.i_stop_signal && (state_q == PLAY);
      keyEvent   = stopSigEff | bus.i_key_stop | bus.i_key_record | bus.i_key_play;
      case (state_q)
         IDLE: begin
            if (!bus.i_key_stop && bus.i_key_record) begin
               state_d    = RECORD;
               clearTimer = 1'b1;
            end else if (!bus.i_key_stop && bus.i_key_play) begin
               state_d    = PLAY;
               clearTimer = 1'b1;
            end
         end
         PLAY: begin
            if (stopSigEff || bus.i_key_stop) begin
               state_d = IDLE;
            end else if (!bus.i_key_record && bus.i_key_play) begin
               state_d = PLAY_PAUSE;
            end
         end
         PLAY_PAUSE: begin
            if (bus.i_key_stop) begin
               state_d = IDLE;
            end else if (bus.i_key_record) begin
               state_d    = RECORD;
               clearTimer = 1'b1;
            end else if (bus.i_key_play) begin
               state_d = PLAY;
            end
         end
         RECORD: begin
            if (bus.i_key_stop) begin
               state_d = IDLE;
            end else if (!bus.i_key_record && bus.i_key_play) begin
               state_d = RECORD_PAUSE;
            end
`ifdef REC_AUTOSTOP_EN
            // Memory is full: stop so the core writes the data length
            if (seconds_q == SEC_MAX) begin
               state_d = IDLE;
            end
`endif
         end
         RECORD_PAUSE: begin
            if (bus.i_key_stop) begin
               state_d = IDLE;
            end else if (bus.i_key_record) begin
               state_d = RECORD;
            end else if (bus.i_key_play) begin
               state_d    = PLAY;
               clearTimer = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output logic: speed register, elapsed timer and event word
   always_comb begin
      speed_d = speed_q;
      if (!keyEvent) begin
         if (bus.i_key_up && !bus.i_key_down && speed_q != 4'd8) begin
            speed_d = speed_q + 4'd1;
         end else if (bus.i_key_down && !bus.i_key_up && speed_q != 4'd1) begin
            speed_d = speed_q - 4'd1;
         end
      end

      tick_d    = tick_q;
      seconds_d = seconds_q;
      if (clearTimer) begin
         tick_d    = '0;
         seconds_d = '0;
      end else if ((state_q == PLAY || state_q == RECORD) && seconds_q < SEC_MAX) begin
         if (tick_q == TICK_LAST) begin
            tick_d    = '0;
            seconds_d = seconds_q + 8'd1;
         end else begin
            tick_d = tick_q + TICK_W'(1);
         end
      end

      // Mode 11 is reported as normal; normal forces speed 1, slow never
      // runs at 1 (the core would not interpolate), interpol is slow-only.
      case (bus.i_sw_mode)
         2'b01:   modeField = 2'b01;
         2'b10:   modeField = 2'b10;
         default: modeField = 2'b00;
      endcase
      if (modeField == 2'b00) begin
         speedField = 4'd1;
      end else if (modeField == 2'b01 && speed_d == 4'd1) begin
         speedField = 4'd2;
      end else begin
         speedField = speed_d;
      end
      interpBit = bus.i_sw_interpol && (modeField == 2'b01);

      // The configuration fields stay frozen while the core is actively
      // playing or recording; they update on entry to or exit from those.
      event_d        = event_q;
      event_d[15:12] = codeOf(state_d);
      if (isCfgState(state_q) || isCfgState(state_d)) begin
         event_d[11:0] = {modeField, speedField, interpBit, 5'b00000};
      end
   end

   // Datapath registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         speed_q   <= 4'd1;
         tick_q    <= '0;
         seconds_q <= '0;
         event_q   <= 16'h3040;
      end else begin
         speed_q   <= speed_d;
         tick_q    <= tick_d;
         seconds_q <= seconds_d;
         event_q   <= event_d;
      end
   end

   assign bus.o_event   = event_q;
   assign bus.o_state   = state_q;
   assign bus.o_speed   = speed_q;
   assign bus.o_seconds = seconds_q;

endmodule

// File: tb/tb_recorder_control.sv
// ----------------------------------------------------------------------------
// tb_recorder_control
// Self-checking bench for recorder_control with TICKS_PER_SEC = 10 and
// MAX_SECONDS = 3. A transition-table reference model runs in lockstep with
// every applied cycle; a vector table and hand sequences add fixed
// expectations, followed by random stimulus. Honours REC_AUTOSTOP_EN.
// ----------------------------------------------------------------------------
module tb_recorder_control;

   localparam int TPS  = 10;
   localparam int MAXS = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;

   recorder_control_if bus ();

   recorder_control #(
      .TICKS_PER_SEC (TPS),
      .MAX_SECONDS   (MAXS)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   // Free-running clock, period 10
   always #5 clk = ~clk;

   int testsRun    = 0;
   int testsFailed = 0;

   logic [1:0] curMode   = 2'd0;
   logic       curInterp = 1'b0;

   // Reference model state: states 0 IDLE,1 PLAY,2 PLAY_PAUSE,3 RECORD,4 RECORD_PAUSE
   int mState, mSpeed, mTicks, mMode, mSpd, mInt;
   int nextTab [5][4];
   bit clrTab  [5][4];
   int codeTab [5];

   typedef struct {
      string      keys;
      logic [1:0] mode;
      logic       intp;
      int eState, eSpeed, eCode, eMode, eSpd, eInt;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mkVec(string k, int md, int ip, int st, int sp,
                                  int cd, int em, int es, int ei);
      vec_t v;
      v.keys = k; v.mode = 2'(md); v.intp = 1'(ip);
      v.eState = st; v.eSpeed = sp; v.eCode = cd;
      v.eMode = em; v.eSpd = es; v.eInt = ei;
      return v;
   endfunction

   function automatic bit isCfg(int s);
      return (s == 0) || (s == 2) || (s == 4);
   endfunction

   function automatic int mkWord(int code, int mode, int spd, int ip);
      return code * 4096 + mode * 1024 + spd * 64 + ip * 32;
   endfunction

   task automatic modelReset();
      mState = 0; mSpeed = 1; mTicks = 0; mMode = 0; mSpd = 1; mInt = 0;
   endtask

   // One clock of the reference model; ev index 0 play,1 record,2 stop,3 stop_signal
   task automatic modelStep(input bit kp, ks, kr, ku, kd, sg, rs,
                            input int mode, input bit ip);
      int ev, nxt, secs;
      bit clr;
      if (rs) begin
         modelReset();
         return;
      end
      ev = -1;
      if (sg && mState == 1) ev = 3;
      else if (ks)           ev = 2;
      else if (kr)           ev = 1;
      else if (kp)           ev = 0;
      nxt = mState;
      clr = 1'b0;
      if (ev >= 0) begin
         nxt = nextTab[mState][ev];
         clr = clrTab[mState][ev];
      end
      secs = mTicks / TPS;
`ifdef REC_AUTOSTOP_EN
      if (mState == 3 && secs == MAXS) begin
         nxt = 0;
         clr = 1'b0;
      end
`endif
      if (clr) mTicks = 0;
      else if ((mState == 1 || mState == 3) && secs < MAXS) mTicks++;
      if (ev < 0) begin
         if (ku && !kd)      mSpeed = (mSpeed < 8) ? mSpeed + 1 : 8;
         else if (kd && !ku) mSpeed = (mSpeed > 1) ? mSpeed - 1 : 1;
      end
      if (isCfg(mState) || isCfg(nxt)) begin
         mMode = (mode == 1 || mode == 2) ? mode : 0;
         mSpd  = (mMode == 0) ? 1 : ((mMode == 1 && mSpeed == 1) ? 2 : mSpeed);
         mInt  = (mMode == 1) ? int'(ip) : 0;
      end
      mState = nxt;
   endtask

   task automatic checkOutput(input string name, input int act, input int exp);
      testsRun++;
      if (act != exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkModel();
      checkOutput("model state",   int'(bus.o_state),   mState);
      checkOutput("model event",   int'(bus.o_event),   mkWord(codeTab[mState], mMode, mSpd, mInt));
      checkOutput("model speed",   int'(bus.o_speed),   mSpeed);
      checkOutput("model seconds", int'(bus.o_seconds), mTicks / TPS);
   endtask

   // keys: p play, s stop, r record, u up, d down, g stop_signal, x reset
   task automatic applyStimulus(input string keys);
      bit kp, ks, kr, ku, kd, sg, rs;
      byte c;
      {kp, ks, kr, ku, kd, sg, rs} = '0;
      for (int i = 0; i < keys.len(); i++) begin
         c = keys[i];
         if (c == "p") kp = 1'b1;
         if (c == "s") ks = 1'b1;
         if (c == "r") kr = 1'b1;
         if (c == "u") ku = 1'b1;
         if (c == "d") kd = 1'b1;
         if (c == "g") sg = 1'b1;
         if (c == "x") rs = 1'b1;
      end
      bus.i_key_play    = kp;
      bus.i_key_stop    = ks;
      bus.i_key_record  = kr;
      bus.i_key_up      = ku;
      bus.i_key_down    = kd;
      bus.i_stop_signal = sg;
      bus.i_sw_mode     = curMode;
      bus.i_sw_interpol = curInterp;
      rst               = rs;
      modelStep(kp, ks, kr, ku, kd, sg, rs, int'(curMode), curInterp);
      @(posedge clk);
      #1;
      checkModel();
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus("");
   endtask

   initial begin
      nextTab = '{'{1, 3, 0, 0}, '{2, 1, 0, 0}, '{1, 3, 0, 2}, '{4, 3, 0, 3}, '{1, 3, 0, 4}};
      clrTab  = '{'{1, 1, 0, 0}, '{0, 0, 0, 0}, '{0, 1, 0, 0}, '{0, 0, 0, 0}, '{1, 0, 0, 0}};
      codeTab = '{3, 1, 2, 4, 2};
      modelReset();

      // Reset then 20 quiet cycles
      applyStimulus("x");
      idle(20);
      checkOutput("reset event",   int'(bus.o_event),   32'h3040);
      checkOutput("reset state",   int'(bus.o_state),   0);
      checkOutput("reset speed",   int'(bus.o_speed),   1);
      checkOutput("reset seconds", int'(bus.o_seconds), 0);

      // Vector table: keys, mode, interpol, then expected state, speed, code, mode, speed field, interpol
      vecs.push_back(mkVec("u",  1, 1, 0, 2, 3, 1, 2, 1));
      vecs.push_back(mkVec("u",  1, 1, 0, 3, 3, 1, 3, 1));
      vecs.push_back(mkVec("u",  1, 1, 0, 4, 3, 1, 4, 1));
      vecs.push_back(mkVec("p",  1, 1, 1, 4, 1, 1, 4, 1));
      vecs.push_back(mkVec("u",  1, 1, 1, 5, 1, 1, 4, 1));
      vecs.push_back(mkVec("p",  1, 1, 2, 5, 2, 1, 5, 1));
      vecs.push_back(mkVec("ud", 1, 1, 2, 5, 2, 1, 5, 1));
      vecs.push_back(mkVec("",   0, 1, 2, 5, 2, 0, 1, 0));
      vecs.push_back(mkVec("",   3, 1, 2, 5, 2, 0, 1, 0));
      vecs.push_back(mkVec("",   2, 1, 2, 5, 2, 2, 5, 0));
      vecs.push_back(mkVec("r",  2, 1, 3, 5, 4, 2, 5, 0));
      vecs.push_back(mkVec("p",  2, 1, 4, 5, 2, 2, 5, 0));
      vecs.push_back(mkVec("s",  2, 1, 0, 5, 3, 2, 5, 0));
      vecs.push_back(mkVec("d",  1, 1, 0, 4, 3, 1, 4, 1));
      vecs.push_back(mkVec("s",  1, 1, 0, 4, 3, 1, 4, 1));
      vecs.push_back(mkVec("pr", 1, 1, 3, 4, 4, 1, 4, 1));
      vecs.push_back(mkVec("gp", 1, 1, 4, 4, 2, 1, 4, 1));
      vecs.push_back(mkVec("p",  1, 1, 1, 4, 1, 1, 4, 1));
      vecs.push_back(mkVec("gp", 1, 1, 0, 4, 3, 1, 4, 1));
      vecs.push_back(mkVec("p",  1, 1, 1, 4, 1, 1, 4, 1));
      vecs.push_back(mkVec("r",  1, 1, 1, 4, 1, 1, 4, 1));
      vecs.push_back(mkVec("s",  1, 1, 0, 4, 3, 1, 4, 1));
      vecs.push_back(mkVec("d",  1, 1, 0, 3, 3, 1, 3, 1));
      vecs.push_back(mkVec("d",  1, 1, 0, 2, 3, 1, 2, 1));
      vecs.push_back(mkVec("d",  1, 1, 0, 1, 3, 1, 2, 1));
      vecs.push_back(mkVec("d",  1, 1, 0, 1, 3, 1, 2, 1));
      for (int s = 2; s <= 8; s++) vecs.push_back(mkVec("u", 1, 1, 0, s, 3, 1, s, 1));
      vecs.push_back(mkVec("u",  1, 1, 0, 8, 3, 1, 8, 1));

      foreach (vecs[i]) begin
         curMode   = vecs[i].mode;
         curInterp = vecs[i].intp;
         applyStimulus(vecs[i].keys);
         checkOutput($sformatf("vec%0d state", i), int'(bus.o_state), vecs[i].eState);
         checkOutput($sformatf("vec%0d speed", i), int'(bus.o_speed), vecs[i].eSpeed);
         checkOutput($sformatf("vec%0d event", i), int'(bus.o_event),
                     mkWord(vecs[i].eCode, vecs[i].eMode, vecs[i].eSpd, vecs[i].eInt));
      end

      // Elapsed timer in PLAY and its saturation
      applyStimulus("p");
      idle(20);
      checkOutput("play 20 cycles seconds", int'(bus.o_seconds), 2);
      idle(15);
      checkOutput("play saturated seconds", int'(bus.o_seconds), 3);
      checkOutput("play saturated state",   int'(bus.o_state),   1);

      // Record / pause / record: timer holds in pause and then continues
      applyStimulus("p");
      applyStimulus("r");
      checkOutput("record code", int'(bus.o_event[15:12]), 4);
      idle(15);
      applyStimulus("p");
      checkOutput("rec pause code", int'(bus.o_event[15:12]), 2);
      idle(20);
      checkOutput("rec pause hold seconds", int'(bus.o_seconds), 1);
      applyStimulus("r");
      checkOutput("record again code", int'(bus.o_event[15:12]), 4);
      idle(3);
      checkOutput("record continue seconds a", int'(bus.o_seconds), 1);
      idle(1);
      checkOutput("record continue seconds b", int'(bus.o_seconds), 2);
      applyStimulus("p");
      applyStimulus("p");
      checkOutput("pause to play code",    int'(bus.o_event[15:12]), 1);
      checkOutput("pause to play seconds", int'(bus.o_seconds),      0);

      // Reset in the middle of PLAY, then down at speed 1
      applyStimulus("x");
      checkOutput("midop reset event",   int'(bus.o_event),   32'h3040);
      checkOutput("midop reset state",   int'(bus.o_state),   0);
      checkOutput("midop reset speed",   int'(bus.o_speed),   1);
      checkOutput("midop reset seconds", int'(bus.o_seconds), 0);
      applyStimulus("d");
      checkOutput("down at 1 speed", int'(bus.o_speed), 1);

      // Recording up to capacity
      applyStimulus("r");
      idle(30);
      checkOutput("full seconds", int'(bus.o_seconds), 3);
      checkOutput("full state",   int'(bus.o_state),   3);
      idle(1);
`ifdef REC_AUTOSTOP_EN
      checkOutput("autostop state", int'(bus.o_state),         0);
      checkOutput("autostop code",  int'(bus.o_event[15:12]),  3);
`else
      checkOutput("no autostop state", int'(bus.o_state),        3);
      checkOutput("no autostop code",  int'(bus.o_event[15:12]), 4);
`endif
      checkOutput("after full seconds", int'(bus.o_seconds), 3);
      idle(5);

      // Random stimulus against the model
      for (int n = 0; n < 800; n++) begin
         string k;
         k = "";
         if ($urandom_range(0, 11) == 0)  k = {k, "p"};
         if ($urandom_range(0, 29) == 0)  k = {k, "s"};
         if ($urandom_range(0, 19) == 0)  k = {k, "r"};
         if ($urandom_range(0, 7)  == 0)  k = {k, "u"};
         if ($urandom_range(0, 7)  == 0)  k = {k, "d"};
         if ($urandom_range(0, 24) == 0)  k = {k, "g"};
         if ($urandom_range(0, 299) == 0) k = {k, "x"};
         if ($urandom_range(0, 29) == 0)  curMode   = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 29) == 0)  curInterp = 1'($urandom_range(0, 1));
         applyStimulus(k);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
